// File: rtl/riscv_muxn_pkg.sv
// Shared types, constants and helpers for the N-input registered operand select.
// Optional 2-entry skid buffer is enabled by defining RISCV_MUXN_SKID_EN.
package riscv_muxn_pkg;

   typedef enum logic [1:0] {EMPTY, FULL, SKID} muxn_state_t;

   localparam logic ZERO = 1'b0;

   // Select width for n inputs; never narrower than one bit.
   function automatic int unsigned muxn_sel_w(input int unsigned n);
      return (n < 2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/riscv_muxn_sel.sv
// Combinational N:1 selector; out-of-range select yields zero data and err set.
module riscv_muxn_sel
   import riscv_muxn_pkg::*;
#(
   parameter  int unsigned WIDTH  = 64,
   parameter  int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W  = muxn_sel_w(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        sel_data_c,
   output logic                    err_c
);

   always_comb begin
      sel_data_c = {WIDTH{ZERO}};
      err_c      = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (32'(sel) == k) begin
            sel_data_c = data[k*WIDTH +: WIDTH];
            err_c      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/riscv_muxn_pipe.sv
// N-input operand select with a registered valid/ready output stage and flush.
// Define RISCV_MUXN_SKID_EN for a 2-entry skid buffer with a registered o_riscv_muxn_ready.
module riscv_muxn_pipe
   import riscv_muxn_pkg::*;
#(
   parameter  int unsigned WIDTH  = 64,
   parameter  int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W  = muxn_sel_w(NUM_IN)
) (
   input  logic                    i_riscv_muxn_clk,
   input  logic                    i_riscv_muxn_rstn,
   input  logic [NUM_IN*WIDTH-1:0] i_riscv_muxn_in,
   input  logic [SEL_W-1:0]        i_riscv_muxn_sel,
   input  logic                    i_riscv_muxn_valid,
   output logic                    o_riscv_muxn_ready,
   output logic [WIDTH-1:0]        o_riscv_muxn_out,
   output logic                    o_riscv_muxn_err,
   output logic                    o_riscv_muxn_valid,
   input  logic                    i_riscv_muxn_ready,
   input  logic                    i_riscv_muxn_flush
);

   logic [WIDTH-1:0] sel_data_c;
   logic             sel_err_c;
   logic             accept_c;
   logic             xfer_c;

   riscv_muxn_sel #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_sel (
      .data       (i_riscv_muxn_in),
      .sel        (i_riscv_muxn_sel),
      .sel_data_c (sel_data_c),
      .err_c      (sel_err_c)
   );

   assign accept_c = i_riscv_muxn_valid & o_riscv_muxn_ready;
   assign xfer_c   = o_riscv_muxn_valid & i_riscv_muxn_ready;

`ifdef RISCV_MUXN_SKID_EN
   muxn_state_t      state;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;

   // Skid FSM: the skid slot only fills while downstream stalls, so ready can be a flop.
   always_ff @(posedge i_riscv_muxn_clk or negedge i_riscv_muxn_rstn) begin
      if (!i_riscv_muxn_rstn) begin
         state              <= EMPTY;
         o_riscv_muxn_out   <= '0;
         o_riscv_muxn_err   <= 1'b0;
         o_riscv_muxn_valid <= 1'b0;
         o_riscv_muxn_ready <= 1'b1;
         skid_data          <= '0;
         skid_err           <= 1'b0;
      end else if (i_riscv_muxn_flush) begin
         state              <= EMPTY;
         o_riscv_muxn_valid <= 1'b0;
         o_riscv_muxn_ready <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept_c) begin
                  state              <= FULL;
                  o_riscv_muxn_valid <= 1'b1;
                  o_riscv_muxn_out   <= sel_data_c;
                  o_riscv_muxn_err   <= sel_err_c;
               end
            end
            FULL: begin
               if (accept_c && xfer_c) begin
                  o_riscv_muxn_out <= sel_data_c;
                  o_riscv_muxn_err <= sel_err_c;
               end else if (accept_c) begin
                  state              <= SKID;
                  o_riscv_muxn_ready <= 1'b0;
                  skid_data          <= sel_data_c;
                  skid_err           <= sel_err_c;
               end else if (xfer_c) begin
                  state              <= EMPTY;
                  o_riscv_muxn_valid <= 1'b0;
               end
            end
            SKID: begin
               if (xfer_c) begin
                  state              <= FULL;
                  o_riscv_muxn_ready <= 1'b1;
                  o_riscv_muxn_out   <= skid_data;
                  o_riscv_muxn_err   <= skid_err;
               end
            end
            default: begin
               state              <= EMPTY;
               o_riscv_muxn_valid <= 1'b0;
               o_riscv_muxn_ready <= 1'b1;
            end
         endcase
      end
   end
`else
   // Single stage: a held item may be replaced on the same edge it drains.
   assign o_riscv_muxn_ready = ~o_riscv_muxn_valid | i_riscv_muxn_ready;

   always_ff @(posedge i_riscv_muxn_clk or negedge i_riscv_muxn_rstn) begin
      if (!i_riscv_muxn_rstn) begin
         o_riscv_muxn_out   <= '0;
         o_riscv_muxn_err   <= 1'b0;
         o_riscv_muxn_valid <= 1'b0;
      end else if (i_riscv_muxn_flush) begin
         o_riscv_muxn_valid <= 1'b0;
      end else if (accept_c) begin
         o_riscv_muxn_valid <= 1'b1;
         o_riscv_muxn_out   <= sel_data_c;
         o_riscv_muxn_err   <= sel_err_c;
      end else if (xfer_c) begin
         o_riscv_muxn_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_muxn_pipe.sv
// Bench for riscv_muxn_pipe: directed tables, corner sequences and a queue reference model.
module tb_riscv_muxn_pipe;

   localparam int unsigned W = 64;
`ifdef RISCV_MUXN_SKID_EN
   localparam int unsigned CAP = 2;
`else
   localparam int unsigned CAP = 1;
`endif

   typedef struct packed {
      logic [W-1:0] d;
      logic         e;
   } item_t;

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] exp_out;
   } vec_t;

   logic           clk = 1'b0;
   logic           rstn;
   always #5 clk = ~clk;

   logic [4*W-1:0] in4;
   logic [1:0]     sel4;
   logic           v4, r4, f4, ordy4, ov4, oerr4;
   logic [W-1:0]   out4;

   logic [3*W-1:0] in3;
   logic [1:0]     sel3;
   logic           v3, r3, f3, ordy3, ov3, oerr3;
   logic [W-1:0]   out3;

   riscv_muxn_pipe #(.WIDTH(W), .NUM_IN(4)) dut4 (
      .i_riscv_muxn_clk   (clk),
      .i_riscv_muxn_rstn  (rstn),
      .i_riscv_muxn_in    (in4),
      .i_riscv_muxn_sel   (sel4),
      .i_riscv_muxn_valid (v4),
      .o_riscv_muxn_ready (ordy4),
      .o_riscv_muxn_out   (out4),
      .o_riscv_muxn_err   (oerr4),
      .o_riscv_muxn_valid (ov4),
      .i_riscv_muxn_ready (r4),
      .i_riscv_muxn_flush (f4)
   );

   riscv_muxn_pipe #(.WIDTH(W), .NUM_IN(3)) dut3 (
      .i_riscv_muxn_clk   (clk),
      .i_riscv_muxn_rstn  (rstn),
      .i_riscv_muxn_in    (in3),
      .i_riscv_muxn_sel   (sel3),
      .i_riscv_muxn_valid (v3),
      .o_riscv_muxn_ready (ordy3),
      .o_riscv_muxn_out   (out3),
      .o_riscv_muxn_err   (oerr3),
      .o_riscv_muxn_valid (ov3),
      .i_riscv_muxn_ready (r3),
      .i_riscv_muxn_flush (f3)
   );

   int    n_chk = 0;
   int    n_fail = 0;
   int    beats = 0;
   item_t q[$];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // In-order queue model: capacity CAP, ready means room for one more item this edge.
   function automatic logic model_ready(input logic drdy);
      if (CAP == 2) return q.size() < 2;
      return (q.size() == 0) || drdy;
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "/valid"}, W'(ov4), W'(q.size() != 0));
      chk({tag, "/ready"}, W'(ordy4), W'(model_ready(r4)));
      if (q.size() != 0) begin
         chk({tag, "/out"}, out4, q[0].d);
         chk({tag, "/err"}, W'(oerr4), W'(q[0].e));
      end
   endtask

   function automatic logic [4*W-1:0] bus_of(input logic [W-1:0] base);
      logic [4*W-1:0] b;
      for (int k = 0; k < 4; k++) b[k*W +: W] = base + W'(k);
      return b;
   endfunction

   function automatic logic [4*W-1:0] rnd_bus();
      logic [4*W-1:0] b;
      for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
      return b;
   endfunction

   // One clock: drive at negedge, check vs model, advance model at posedge.
   task automatic cycle(input logic v, input logic [1:0] s, input logic [4*W-1:0] d,
                        input logic r, input logic f, input string tag);
      logic  acc, xf;
      item_t it;
      v4 = v; sel4 = s; in4 = d; r4 = r; f4 = f;
      #1;
      check_model(tag);
      if (ov4 && r4) beats++;
      acc  = v && model_ready(r);
      xf   = (q.size() != 0) && r;
      it.d = d[32'(s)*W +: W];
      it.e = 1'b0;
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (xf) void'(q.pop_front());
         if (acc) q.push_back(it);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "/out4"}, out4, '0);
      chk({tag, "/err4"}, W'(oerr4), '0);
      chk({tag, "/valid4"}, W'(ov4), '0);
      chk({tag, "/ready4"}, W'(ordy4), W'(1));
      chk({tag, "/out3"}, out3, '0);
      chk({tag, "/err3"}, W'(oerr3), '0);
      chk({tag, "/valid3"}, W'(ov3), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      logic [W-1:0] a_v, b_v, c_v;

      rstn = 1'b0;
      in4 = '0; sel4 = '0; v4 = 1'b0; r4 = 1'b0; f4 = 1'b0;
      in3 = '0; sel3 = '0; v3 = 1'b0; r3 = 1'b1; f3 = 1'b0;
      #2;
      chk_reset_vals("por");
      @(negedge clk);
      rstn = 1'b1;

      // Select sweep from a table.
      for (int k = 0; k < 4; k++) begin
         tbl[k].sel     = 2'(k);
         tbl[k].exp_out = 64'h1000 + W'(k);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, tbl[i].sel, bus_of(64'h1000), 1'b1, 1'b0, "sweep");
         chk("sweep_out", out4, tbl[i].exp_out);
         chk("sweep_err", W'(oerr4), '0);
      end
      cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, "drain");

      // Out-of-range select on a 3-input instance.
      in3 = {3{64'hFFFF}}; sel3 = 2'd3; v3 = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("oor_out", out3, '0);
      chk("oor_err", W'(oerr3), W'(1));
      chk("oor_valid", W'(ov3), W'(1));
      sel3 = 2'd1;
      @(posedge clk); @(negedge clk);
      chk("inr_out", out3, 64'hFFFF);
      chk("inr_err", W'(oerr3), '0);
      v3 = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("oor_drain", W'(ov3), '0);

      // Back-pressure: A then B while downstream stalls.
      a_v = 64'hA0A0; b_v = 64'hB0B0; c_v = 64'hC0C0;
      cycle(1'b1, 2'd0, bus_of(a_v), 1'b0, 1'b0, "bpA");
      cycle(1'b1, 2'd0, bus_of(b_v), 1'b0, 1'b0, "bpB");
      chk("bp_held", out4, a_v);
      chk("bp_ready", W'(ordy4), '0);
      cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, "bp_rel1");
      chk("bp_second", W'(ov4), W'(CAP == 2));
      cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, "bp_rel2");
      chk("bp_empty", W'(ov4), '0);
      chk("bp_ready_back", W'(ordy4), W'(1));

      // Flush while full (SKID in the skid build) with a new item C offered.
      cycle(1'b1, 2'd0, bus_of(a_v), 1'b0, 1'b0, "flA");
      cycle(1'b1, 2'd0, bus_of(b_v), 1'b0, 1'b0, "flB");
      cycle(1'b1, 2'd0, bus_of(c_v), 1'b0, 1'b1, "flC");
      chk("flush_valid", W'(ov4), '0);
      chk("flush_ready", W'(ordy4), W'(1));
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, "post_flush");
         chk("flush_no_c", W'(ov4), '0);
      end

      // Full throughput: 100 items back to back.
      beats = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 2'($urandom_range(3)), rnd_bus(), 1'b1, 1'b0, "tput");
         chk("tput_valid", W'(ov4), W'(1));
      end
      cycle(1'b0, 2'd0, '0, 1'b1, 1'b0, "tput_tail");
      chk("tput_beats", W'(beats), W'(100));

      // Mid-stream asynchronous reset with items held.
      cycle(1'b1, 2'd2, bus_of(64'h5555), 1'b0, 1'b0, "pre_rst");
      v3 = 1'b1; sel3 = 2'd0; r3 = 1'b0;
      cycle(1'b1, 2'd3, bus_of(64'h7777), 1'b0, 1'b0, "pre_rst2");
      #2;
      rstn = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      q.delete();
      v3 = 1'b0; r3 = 1'b1;
      @(negedge clk);
      rstn = 1'b1;

      // Randomised traffic with occasional flush.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(1)), 2'($urandom_range(3)), rnd_bus(),
               1'($urandom_range(1)), 1'($urandom_range(15) == 0), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_muxn_pipe.md
# riscv_muxn_pipe

Parametrised N-input operand select with a registered, flow-controlled output stage. Generalises the core's fixed 3-input operand multiplexer to any width and input count, adds valid/ready handshaking, a pipeline flush, and an out-of-range-select error flag. Sits between the forwarding/operand-select logic and the execute stage, where it provides a timing break without losing back-pressure.

## Interface
- `WIDTH`, 64, data width of each input and of the output.
- `NUM_IN`, 4, number of data inputs; must be ≥ 2. `SEL_W = $clog2(NUM_IN)` is derived and is not overridable.
- `i_riscv_muxn_clk`  in  1  clock; all state changes on the rising edge.
- `i_riscv_muxn_rstn`  in  1  reset; asynchronous, active-low.
- `i_riscv_muxn_in`  in  NUM_IN*WIDTH  flat input bus; input k occupies bits [k*WIDTH +: WIDTH].
- `i_riscv_muxn_sel`  in  SEL_W  binary select; sampled with the data.
- `i_riscv_muxn_valid`  in  1  upstream valid.
- `o_riscv_muxn_ready`  out  1  upstream may transfer.
- `o_riscv_muxn_out`  out  WIDTH  registered selected data.
- `o_riscv_muxn_err`  out  1  registered; set when the captured sel was ≥ NUM_IN.
- `o_riscv_muxn_valid`  out  1  output holds a valid item.
- `i_riscv_muxn_ready`  in  1  downstream accepts.
- `i_riscv_muxn_flush`  in  1  synchronous discard of all held items.

## Operation
- Accept: upstream transfers on a cycle where `i_valid & o_ready`. Output transfers on a cycle where `o_valid & i_ready`.
- Select: if sel < NUM_IN, the selected data is input[sel] and err is 0. If sel ≥ NUM_IN, the data is all-zero and err is 1. Err travels with its data item.
- Output data and err hold stable while `o_valid & !i_ready`.
- Flush: on the next edge, all valid flags clear. Any input accepted in the flush cycle is discarded. `o_ready` returns to 1.
- Flush takes priority over accept and over output transfer. Data registers may keep stale contents; only the valid flags matter.
- Reset (asynchronous, at any time, including mid-transfer): out = 0, err = 0, o_valid = 0, skid buffer empty, o_ready = 1. The state machine goes to EMPTY.

## Timing
- Latency is 1 cycle: an item accepted at edge n is visible at the output after edge n, with o_valid = 1.
- Sustained throughput is 1 item/cycle while `i_ready = 1`.
- Without `RISCV_MUXN_SKID_EN`:
  - `o_ready = !o_valid | i_ready`, a combinational path from `i_ready`.
  - Simultaneous output transfer and accept replaces the held item in the same edge.
- With `RISCV_MUXN_SKID_EN`, the state machine is:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on output transfer with no accept.
  - FULL → FULL on output transfer and accept together (main register reloads), or with neither.
  - FULL → SKID on accept while `!i_ready`; the new item goes to the skid register.
  - SKID → FULL on output transfer; the skid item moves to the main register.
  - Any state → EMPTY on flush.
- In SKID mode, `o_ready` is a direct register output: 0 in SKID, 1 otherwise. Items leave in FIFO order.

## Configuration
- Macro: `RISCV_MUXN_SKID_EN`.
- Defined: 2-entry skid buffer. `o_ready` is registered, so there is no combinational ready path through the block. Max occupancy is 2.
- Undefined: single output register with combinational ready. Max occupancy is 1.
- Latency and data behaviour are identical in both builds.

## Structure
- Package `riscv_muxn_pkg`:
  - state enum {EMPTY, FULL, SKID};
  - a select-width helper function;
  - the ZERO default constant.
- Sub-module `riscv_muxn_sel`: purely combinational N:1 selector with zero default and the err output. It is instantiated once; the skid path reuses the captured result.

## Test plan
- Reset: NUM_IN=4, WIDTH=64, hold rstn=0 mid-stream → out=0, err=0, o_valid=0, o_ready=1 immediately, without waiting for a clock edge.
- Select sweep: in[k]=0x1000+k, sel=0..3, i_ready=1 → out=0x1000..0x1003 one cycle after each accept, err=0.
- Out of range: NUM_IN=3, sel=3, in[*]=0xFFFF → out=0, err=1. The next item with sel=1 → err=0.
- Back-pressure (skid build): i_ready=0, send A then B → A held at the output, o_ready=0 after B. Raise i_ready → A then B delivered in order, o_ready=1 again.
- Flush: in the SKID state, flush=1 with i_valid=1 carrying C → next cycle o_valid=0, o_ready=1, and C is never output.
- Full throughput: 100 back-to-back items with i_ready=1 → 100 outputs on consecutive cycles, in order, with no bubbles, in both builds.
